// File: rtl/fpu_div_issuer.sv
// Start/done handshake issuer for the FP divide unit (request/response channels).
// Define FPU_DIV_ISSUER_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT_CYCLES.
module fpu_div_issuer #(
  parameter int WIDTH          = 16,
  parameter int FLAGW          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_cond,
  output logic [FLAGW-1:0] rsp_flags,
  output logic             rsp_timeout,
  output logic [WIDTH-1:0] div_in1,
  output logic [WIDTH-1:0] div_in2,
  output logic             div_start,
  output logic             div_reset,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_out,
  input  logic [3:0]       div_cond,
  input  logic [FLAGW-1:0] div_flags
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RSP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       cond_q, cond_d;
  logic [FLAGW-1:0] flags_q, flags_d;
  logic             tmo_hit;

`ifdef FPU_DIV_ISSUER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  // Last WAIT cycle is the one in which the count reaches TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == WAIT) && !div_done &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (div_done) begin
        tmo_d = 1'b0;
      end else if (tmo_hit) begin
        tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign rsp_timeout = tmo_q;
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = (TIMEOUT_CYCLES < 2);
  assign tmo_hit        = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    cond_d  = cond_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          in1_d   = req_a;
          in2_d   = req_b;
          state_d = CLEAR;
        end
      end
      CLEAR:  state_d = LAUNCH;
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          res_d   = div_out;
          cond_d  = div_cond;
          flags_d = div_flags;
          state_d = RSP;
        end else if (tmo_hit) begin
          res_d   = '0;
          cond_d  = '0;
          flags_d = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      cond_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
    end
  end

  // The unit is held in reset whenever the issuer itself is.
  assign div_reset  = ~reset_n | (state_q == CLEAR);
  assign div_start  = (state_q == LAUNCH);
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RSP);
  assign div_in1    = in1_q;
  assign div_in2    = in2_q;
  assign rsp_result = res_q;
  assign rsp_cond   = cond_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_fpu_div_issuer.sv
// Directed bench for fpu_div_issuer with a 5-cycle divide unit model.
// Covers FPU_DIV_ISSUER_TIMEOUT_EN when the macro is defined.
module tb_fpu_div_issuer;

  localparam int W  = 16;
  localparam int FW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a, req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_cond;
  logic [FW-1:0] rsp_flags;
  logic          rsp_timeout;
  logic [W-1:0]  div_in1, div_in2;
  logic          div_start, div_reset;
  logic          div_done;
  logic [W-1:0]  div_out;
  logic [3:0]    div_cond;
  logic [FW-1:0] div_flags;

  int total = 0;
  int bad   = 0;
  int rst_pulses = 0;
  logic hang = 1'b0;

  fpu_div_issuer #(
    .WIDTH(W), .FLAGW(FW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cond(rsp_cond),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .div_in1(div_in1), .div_in2(div_in2),
    .div_start(div_start), .div_reset(div_reset),
    .div_done(div_done), .div_out(div_out),
    .div_cond(div_cond), .div_flags(div_flags)
  );

  always #5 clock = ~clock;

  // Known quotients; cond is {Z,C,N,V}.
  function automatic logic [19:0] ref_div(logic [15:0] a, logic [15:0] b);
    if (a == 16'h4600 && b == 16'h4000) return {4'b0000, 16'h4200};
    if (a == 16'h3C00 && b == 16'h3800) return {4'b0000, 16'h4000};
    if (a == 16'hC400 && b == 16'h4000) return {4'b0010, 16'hC000};
    if (a == 16'h4000 && b == 16'h4000) return {4'b0000, 16'h3C00};
    return {4'b1111, 16'hDEAD};
  endfunction

  // Unit model: done parks high until the unit is reset.
  int mcnt = 0;
  logic mbusy = 1'b0;
  always @(posedge clock) begin
    if (div_reset) begin
      mbusy    <= 1'b0;
      mcnt     <= 0;
      div_done <= 1'b0;
    end else if (div_start) begin
      mbusy <= 1'b1;
      mcnt  <= 1;
      {div_cond, div_out} <= ref_div(div_in1, div_in2);
    end else if (mbusy) begin
      mcnt <= mcnt + 1;
      if (mcnt == 4 && !hang) begin
        div_done <= 1'b1;
        mbusy    <= 1'b0;
      end
    end
  end

  always @(posedge clock)
    if (reset_n && div_reset) rst_pulses <= rst_pulses + 1;

  initial begin
    div_done  = 1'b0;
    div_out   = '0;
    div_cond  = '0;
    div_flags = '0;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(output int n, input int lim);
    n = 0;
    while (!rsp_valid && n < lim) begin
      tick();
      n++;
    end
  endtask

  // Offer a request and step past the accepting edge into CLEAR.
  task automatic issue(logic [15:0] a, logic [15:0] b);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  int n;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_reset", div_reset, 1);
    chk("rst_div_start", div_start, 0);
    chk("rst_in1", div_in1, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_timeout", rsp_timeout, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_div_reset", div_reset, 0);

    // Basic divide with operand isolation
    issue(16'h4600, 16'h4000);
    req_a = 16'hFFFF;
    req_b = 16'hFFFF;
    chk("clr_div_reset", div_reset, 1);
    chk("clr_div_start", div_start, 0);
    chk("clr_req_ready", req_ready, 0);
    tick();
    chk("lau_div_start", div_start, 1);
    chk("lau_div_reset", div_reset, 0);
    tick();
    chk("wait_div_start", div_start, 0);
    wait_rsp(n, 50);
    chk("basic_latency", n, 5);
    chk("basic_result", rsp_result, 16'h4200);
    chk("basic_cond", rsp_cond, 4'b0000);
    chk("basic_flags", rsp_flags, 0);
    chk("basic_timeout", rsp_timeout, 0);
    chk("iso_in1", div_in1, 16'h4600);
    chk("iso_in2", div_in2, 16'h4000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("basic_idle", req_ready, 1);
    chk("basic_rsp_low", rsp_valid, 0);

    // Backpressure
    issue(16'h3C00, 16'h3800);
    wait_rsp(n, 50);
    chk("bp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", rsp_result, 16'h4000);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_hold_valid", rsp_valid, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle", req_ready, 1);

    // Back-to-back
    rst_pulses = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 16'h4600;
    req_b = 16'h4000;
    tick();
    req_a = 16'hC400;
    req_b = 16'h4000;
    wait_rsp(n, 50);
    chk("b2b_r1", rsp_result, 16'h4200);
    chk("b2b_rsp_rdy", req_ready, 0);
    tick();
    chk("b2b_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_in1", div_in1, 16'hC400);
    chk("b2b_clr", div_reset, 1);
    wait_rsp(n, 50);
    chk("b2b_r2", rsp_result, 16'hC000);
    chk("b2b_cond", rsp_cond, 4'b0010);
    tick();
    rsp_ready = 1'b0;
    chk("b2b_pulses", rst_pulses, 2);

    // Reset mid-WAIT
    issue(16'h4600, 16'h4000);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_div_reset", div_reset, 1);
    chk("mrst_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_in1", div_in1, 0);
    issue(16'h4000, 16'h4000);
    wait_rsp(n, 50);
    chk("mrst_result", rsp_result, 16'h3C00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Stuck unit
    hang = 1'b1;
    issue(16'h4600, 16'h4000);
    tick();
    tick();
`ifdef FPU_DIV_ISSUER_TIMEOUT_EN
    wait_rsp(n, 50);
    chk("tmo_latency", n, 8);
    chk("tmo_flag", rsp_timeout, 1);
    chk("tmo_result", rsp_result, 0);
    chk("tmo_cond", rsp_cond, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("tmo_idle", req_ready, 1);
`else
    wait_rsp(n, 100);
    chk("notmo_valid", rsp_valid, 0);
    chk("notmo_timeout", rsp_timeout, 0);
`endif
    hang = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
